nios1_mem_width_adapter: RTL and testbench
==========================================

Name: nios1_mem_width_adapter

Overview:
- Upstream neighbour of the 16-bit single-port on-chip RAM: a 4096 x 16 array with byte enables, registered address, unregistered q, 1-cycle read latency.
- Presents a 32-bit Avalon-MM slave with waitrequest to the Nios II data master.
- Splits each 32-bit access into two sequential 16-bit RAM accesses: low half first, then high half.
- Reassembles read data and stalls the master via waitrequest until the access completes.

Parameters:
- ADDR_W, 11, 32-bit word address width on the slave side; the RAM-side address is ADDR_W+1 bits.
- INIT_WAIT, 0, cycles of waitrequest held after reset release before the first request is accepted (0..15).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- s_address  input  ADDR_W  32-bit word address
- s_byteenable  input  4  byte lanes [3:0]
- s_chipselect  input  1  slave select
- s_read  input  1  read request
- s_write  input  1  write request
- s_writedata  input  32  write data
- s_readdata  output  32  read data; valid in the cycle s_waitrequest is low for a read
- s_waitrequest  output  1  stall to master
- m_address  output  ADDR_W+1  RAM half-word address
- m_byteenable  output  2  RAM byte enables
- m_chipselect  output  1  RAM chipselect
- m_write  output  1  RAM write
- m_writedata  output  16  RAM write data
- m_readdata  input  16  RAM q; valid the cycle after its address is presented

Behaviour:
- Reset (async, reset_n low):
  - State = IDLE (or WAIT if INIT_WAIT>0).
  - s_waitrequest=1; s_readdata=0; all m_* = 0; capture registers cleared.
  - Reset mid-transaction aborts it; no further RAM write pulse is issued.
- States: WAIT, IDLE, LO, HI, CAP, DONE. Registered state; m_* driven from registered request copies.
- WAIT: down-counter from INIT_WAIT; at 0 go to IDLE.
- IDLE:
  - s_waitrequest=1.
  - On s_chipselect & (s_read | s_write): latch address, byteenable, writedata and the op; go to LO.
  - Write has priority if read and write are both high.
- LO:
  - m_address={addr,1'b0}; m_chipselect=1; m_byteenable=be[1:0] (2'b11 on read); m_writedata=wd[15:0]; m_write=op_wr.
  - Next state: HI.
- HI:
  - m_address={addr,1'b1}; m_byteenable=be[3:2] (2'b11 on read); m_writedata=wd[31:16]; m_write=op_wr.
  - On read, capture m_readdata into lo_q at the end of the cycle.
  - Next state: CAP if read, DONE if write.
- CAP (read only): m_chipselect=0; capture m_readdata into hi_q; go to DONE.
- DONE:
  - s_waitrequest=0 for exactly one cycle; s_readdata={hi_q,lo_q} (write: holds last read value).
  - Next state: IDLE. Requests are never accepted in DONE, so back-to-back accesses are separated by one IDLE cycle.
- Latency (request-present cycle = 0): write completes at cycle 3 (waitrequest low), read at cycle 4.
- m_write is asserted only in LO and HI with m_chipselect=1; never two writes to the same half per transaction.
- Address wrap: s_address all-ones maps to RAM addresses 2*max and 2*max+1; no carry out.
- Master changing inputs while stalled is ignored; only values latched in IDLE are used.
- s_chipselect low in IDLE: no RAM activity; m_chipselect=0.

Optional Feature:
- Macro: NIOS1_MEM_ADAPT_SKIP_EN.
- Defined:
  - On writes, a half whose byteenable pair is 2'b00 is skipped entirely: no cycle, no m_chipselect.
  - be=4'b0011: IDLE->LO->DONE. be=4'b1100: IDLE->HI->DONE. be=0: IDLE->DONE.
  - Write latency becomes 1-3 cycles. Reads are unaffected.
- Undefined: both halves are always issued; a zero-enable half is driven with m_byteenable=2'b00 and m_write=1 (harmless).

Decomposition:
- Package nios1_mem_adapt_pkg holds:
  - state enum (WAIT, IDLE, LO, HI, CAP, DONE)
  - constants HALF_W=16, WORD_W=32, BE_HALF=2
- Single module; no sub-module warranted (FSM plus capture registers only).

Test Plan:
- Reset then write 0xDEADBEEF to addr 0x005, be=4'hF -> RAM writes 0xBEEF @0x00A and 0xDEAD @0x00B; waitrequest low in cycle 3 only.
- Read addr 0x005 after the write -> s_readdata=0xDEADBEEF in cycle 4 with waitrequest low; exactly two m_chipselect cycles.
- Write be=4'b1100 data 0x12345678 -> only the high half is updated; readback = 0x1234BEEF. With SKIP_EN: a single RAM cycle, done in cycle 2.
- Assert reset_n low during HI of a write -> all m_* = 0 immediately; no high-half write; the following read returns the old high half.
- Read and write high simultaneously on addr 0x7FF -> treated as a write to RAM 0xFFE/0xFFF; no wrap to 0.
- INIT_WAIT=4: request held from reset release -> accepted only after 4 WAIT cycles; waitrequest high throughout.

Source files
------------

// File: rtl/nios1_mem_adapt_pkg.sv
// nios1_mem_adapt_pkg: shared state encoding and widths for the
// 32-bit Avalon slave to 16-bit on-chip RAM width adapter.
package nios1_mem_adapt_pkg;

    localparam int HALF_W  = 16;
    localparam int WORD_W  = 32;
    localparam int BE_HALF = 2;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_CAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/nios1_mem_width_adapter.sv
// nios1_mem_width_adapter: splits 32-bit Avalon accesses into two 16-bit RAM
// accesses (low half first). Optional macro NIOS1_MEM_ADAPT_SKIP_EN skips
// write halves whose byte enables are all zero.
module nios1_mem_width_adapter
    import nios1_mem_adapt_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int INIT_WAIT = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    s_address,
    input  logic [3:0]           s_byteenable,
    input  logic                 s_chipselect,
    input  logic                 s_read,
    input  logic                 s_write,
    input  logic [WORD_W-1:0]    s_writedata,
    output logic [WORD_W-1:0]    s_readdata,
    output logic                 s_waitrequest,
    output logic [ADDR_W:0]      m_address,
    output logic [BE_HALF-1:0]   m_byteenable,
    output logic                 m_chipselect,
    output logic                 m_write,
    output logic [HALF_W-1:0]    m_writedata,
    input  logic [HALF_W-1:0]    m_readdata
);

    localparam logic [3:0] WAIT_LOAD =
        (INIT_WAIT > 0) ? 4'(INIT_WAIT - 1) : 4'd0;
    localparam state_t RST_STATE =
        (INIT_WAIT > 0) ? ST_WAIT : ST_IDLE;

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_first;
    state_t              w_after_lo;
    logic [3:0]          r_wait;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_be;
    logic [WORD_W-1:0]   r_wd;
    logic                r_wr;
    logic [HALF_W-1:0]   r_lo_q;
    logic [HALF_W-1:0]   r_hi_q;
    logic                w_req;

    assign w_req = s_chipselect & (s_read | s_write);

`ifdef NIOS1_MEM_ADAPT_SKIP_EN
    // A write half with no enabled bytes costs no RAM cycle at all.
    assign w_first =
        !s_write                   ? ST_LO :
        (|s_byteenable[1:0])       ? ST_LO :
        (|s_byteenable[3:2])       ? ST_HI : ST_DONE;
    assign w_after_lo =
        (r_wr && !(|r_be[3:2]))    ? ST_DONE : ST_HI;
`else
    assign w_first    = ST_LO;
    assign w_after_lo = ST_HI;
`endif

    // State register and post-reset wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RST_STATE;
            r_wait  <= WAIT_LOAD;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_WAIT && r_wait != 4'd0)
                r_wait <= r_wait - 4'd1;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_WAIT: if (r_wait == 4'd0) w_state_nxt = ST_IDLE;
            ST_IDLE: if (w_req) w_state_nxt = w_first;
            ST_LO:   w_state_nxt = w_after_lo;
            ST_HI:   w_state_nxt = r_wr ? ST_DONE : ST_CAP;
            ST_CAP:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch in IDLE and read-half capture; write wins a tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_be   <= '0;
            r_wd   <= '0;
            r_wr   <= 1'b0;
            r_lo_q <= '0;
            r_hi_q <= '0;
        end else begin
            if (r_state == ST_IDLE && w_req) begin
                r_addr <= s_address;
                r_be   <= s_byteenable;
                r_wd   <= s_writedata;
                r_wr   <= s_write;
            end
            if (r_state == ST_HI && !r_wr)
                r_lo_q <= m_readdata;
            if (r_state == ST_CAP)
                r_hi_q <= m_readdata;
        end
    end

    // RAM-side and stall outputs from state and latched request
    always_comb begin
        m_address     = '0;
        m_byteenable  = '0;
        m_chipselect  = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        s_waitrequest = 1'b1;
        unique case (r_state)
            ST_LO: begin
                m_address    = {r_addr, 1'b0};
                m_byteenable = r_wr ? r_be[1:0] : 2'b11;
                m_chipselect = 1'b1;
                m_write      = r_wr;
                m_writedata  = r_wd[HALF_W-1:0];
            end
            ST_HI: begin
                m_address    = {r_addr, 1'b1};
                m_byteenable = r_wr ? r_be[3:2] : 2'b11;
                m_chipselect = 1'b1;
                m_write      = r_wr;
                m_writedata  = r_wd[WORD_W-1:HALF_W];
            end
            ST_DONE: s_waitrequest = 1'b0;
            default: ;
        endcase
    end

    assign s_readdata = {r_hi_q, r_lo_q};

endmodule

// File: tb/tb_nios1_mem_width_adapter.sv
// tb_nios1_mem_width_adapter: directed table-driven bench with a behavioural
// 4096x16 RAM; second instance covers the post-reset wait window.
`timescale 1ns/1ps
module tb_nios1_mem_width_adapter;

`ifdef NIOS1_MEM_ADAPT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic        rd;
        logic [10:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          lat;
        int          ncs;
        int          nwr;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [10:0] s_address;
    logic [3:0]  s_byteenable;
    logic        s_chipselect;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        s_waitrequest;
    logic [11:0] m_address;
    logic [1:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata;

    logic        w_reset_n;
    logic [10:0] w_s_address;
    logic [3:0]  w_s_byteenable;
    logic        w_s_chipselect;
    logic        w_s_read;
    logic        w_s_write;
    logic [31:0] w_s_writedata;
    logic [31:0] w_s_readdata;
    logic        w_s_waitrequest;
    logic [11:0] w_m_address;
    logic [1:0]  w_m_byteenable;
    logic        w_m_chipselect;
    logic        w_m_write;
    logic [15:0] w_m_writedata;
    logic [15:0] w_m_readdata;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:4095];
    logic [11:0] ram_a;

    nios1_mem_width_adapter #(.ADDR_W(11), .INIT_WAIT(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_byteenable(s_byteenable),
        .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .s_waitrequest(s_waitrequest),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata)
    );

    nios1_mem_width_adapter #(.ADDR_W(11), .INIT_WAIT(4)) dut_w (
        .clk(clk), .reset_n(w_reset_n),
        .s_address(w_s_address), .s_byteenable(w_s_byteenable),
        .s_chipselect(w_s_chipselect), .s_read(w_s_read),
        .s_write(w_s_write), .s_writedata(w_s_writedata),
        .s_readdata(w_s_readdata), .s_waitrequest(w_s_waitrequest),
        .m_address(w_m_address), .m_byteenable(w_m_byteenable),
        .m_chipselect(w_m_chipselect), .m_write(w_m_write),
        .m_writedata(w_m_writedata), .m_readdata(w_m_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered address, unregistered q, byte enables
    always @(posedge clk) begin
        if (m_chipselect) begin
            ram_a <= m_address;
            if (m_write) begin
                if (m_byteenable[0]) mem[m_address][7:0]  <= m_writedata[7:0];
                if (m_byteenable[1]) mem[m_address][15:8] <= m_writedata[15:8];
            end
        end
    end
    assign m_readdata = mem[ram_a];
    assign w_m_readdata = 16'hA5C3;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, output int lat, output int ncs,
                           output int nwr, output logic [31:0] rdat);
        int n;
        n = 0; lat = -1; ncs = 0; nwr = 0; rdat = '0;
        s_chipselect = 1'b1;
        s_read       = v.rd;
        s_write      = v.wr;
        s_address    = v.addr;
        s_byteenable = v.be;
        s_writedata  = v.wd;
        while (n < 20) begin
            @(negedge clk);
            if (m_chipselect) ncs++;
            if (m_chipselect && m_write) nwr++;
            if (!s_waitrequest) begin
                lat  = n;
                rdat = s_readdata;
                break;
            end
            @(posedge clk); #1;
            if (n == 0) begin
                s_address    = ~v.addr;
                s_writedata  = ~v.wd;
                s_byteenable = ~v.be;
            end
            n++;
        end
        @(posedge clk); #1;
        s_chipselect = 1'b0;
        s_read       = 1'b0;
        s_write      = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        int lat, ncs, nwr;
        logic [31:0] rdat;
        run_txn(v, lat, ncs, nwr, rdat);
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " cs cycles"}, ncs, v.ncs);
        chk({tag, " write pulses"}, nwr, v.nwr);
        chk({tag, " readdata"}, rdat, v.exp_rd);
        @(negedge clk);
        chk({tag, " wait after done"}, {31'b0, s_waitrequest}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt [11];
        vec_t v;
        int n, ncs, first_cs;
        bit done;

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        ram_a = '0;
        reset_n = 1'b0; w_reset_n = 1'b0;
        s_address = '0; s_byteenable = '0; s_chipselect = 1'b0;
        s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
        w_s_address = '0; w_s_byteenable = '0; w_s_chipselect = 1'b0;
        w_s_read = 1'b0; w_s_write = 1'b0; w_s_writedata = '0;

        vt[0]  = '{1'b1, 1'b0, 11'h005, 4'hF, 32'hDEADBEEF, 32'h00000000, 3, 2, 2};
        vt[1]  = '{1'b0, 1'b1, 11'h005, 4'hF, 32'h00000000, 32'hDEADBEEF, 4, 2, 0};
        vt[2]  = '{1'b1, 1'b0, 11'h005, 4'hC, 32'h12345678, 32'hDEADBEEF,
                   SKIP ? 2 : 3, SKIP ? 1 : 2, SKIP ? 1 : 2};
        vt[3]  = '{1'b0, 1'b1, 11'h005, 4'hF, 32'h00000000, 32'h1234BEEF, 4, 2, 0};
        vt[4]  = '{1'b1, 1'b1, 11'h7FF, 4'hF, 32'hCAFEF00D, 32'h1234BEEF, 3, 2, 2};
        vt[5]  = '{1'b0, 1'b1, 11'h7FF, 4'hF, 32'h00000000, 32'hCAFEF00D, 4, 2, 0};
        vt[6]  = '{1'b1, 1'b0, 11'h123, 4'h3, 32'hAAAA5555, 32'hCAFEF00D,
                   SKIP ? 2 : 3, SKIP ? 1 : 2, SKIP ? 1 : 2};
        vt[7]  = '{1'b1, 1'b0, 11'h123, 4'h0, 32'hFFFFFFFF, 32'hCAFEF00D,
                   SKIP ? 1 : 3, SKIP ? 0 : 2, SKIP ? 0 : 2};
        vt[8]  = '{1'b0, 1'b1, 11'h123, 4'hF, 32'h00000000, 32'h00005555, 4, 2, 0};
        vt[9]  = '{1'b1, 1'b0, 11'h124, 4'h6, 32'h11223344, 32'h00005555, 3, 2, 2};
        vt[10] = '{1'b0, 1'b1, 11'h124, 4'hF, 32'h00000000, 32'h00223300, 4, 2, 0};

        #1;
        chk("reset m_outputs",
            {m_address, m_byteenable, m_chipselect, m_write, m_writedata}, 32'd0);
        chk("reset waitrequest", {31'b0, s_waitrequest}, 32'd1);
        chk("reset readdata", s_readdata, 32'd0);

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) apply(vt[i], $sformatf("v%0d", i));

        chk("wrap ram FFE", {16'b0, mem[12'hFFE]}, 32'h0000F00D);
        chk("wrap ram FFF", {16'b0, mem[12'hFFF]}, 32'h0000CAFE);
        chk("no wrap ram 000", {16'b0, mem[12'h000]}, 32'h0);
        chk("no wrap ram 001", {16'b0, mem[12'h001]}, 32'h0);

        // reset asserted while the high half of a write is on the bus
        s_chipselect = 1'b1; s_write = 1'b1; s_read = 1'b0;
        s_address = 11'h005; s_byteenable = 4'hF; s_writedata = 32'h55556666;
        @(posedge clk); #1;
        chk("abort LO addr", 32'(m_address), 32'h00A);
        @(posedge clk); #1;
        chk("abort HI addr", 32'(m_address), 32'h00B);
        reset_n = 1'b0;
        #1;
        chk("abort m_outputs",
            {m_address, m_byteenable, m_chipselect, m_write, m_writedata}, 32'd0);
        chk("abort waitrequest", {31'b0, s_waitrequest}, 32'd1);
        chk("abort readdata", s_readdata, 32'd0);
        s_chipselect = 1'b0; s_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("abort lo written", {16'b0, mem[12'h00A]}, 32'h00006666);
        chk("abort hi kept", {16'b0, mem[12'h00B]}, 32'h00001234);
        v = '{1'b0, 1'b1, 11'h005, 4'hF, 32'h0, 32'h12346666, 4, 2, 0};
        apply(v, "after abort read");

        // INIT_WAIT=4 instance: request held from reset release
        n = 0; ncs = 0; first_cs = -1; done = 1'b0;
        @(negedge clk);
        w_reset_n = 1'b1;
        w_s_chipselect = 1'b1; w_s_read = 1'b1;
        w_s_address = 11'h010; w_s_byteenable = 4'hF;
        while (n < 30 && !done) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (w_m_chipselect) begin
                ncs++;
                if (first_cs < 0) first_cs = n;
            end
            if (!w_s_waitrequest) done = 1'b1;
        end
        chk("initwait done edge", n, 8);
        chk("initwait first cs edge", first_cs, 5);
        chk("initwait cs cycles", ncs, 2);
        chk("initwait readdata", w_s_readdata, 32'hA5C3A5C3);
        w_s_chipselect = 1'b0; w_s_read = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
